// File: rtl/usbcdc_txbuf.sv
`default_nettype none
// ============================================================================
//  Module   : usbcdc_txbuf
//  Purpose  : Byte-wide console transmit buffer in front of the USB CDC bulk
//             IN endpoint. Holds bytes until a line terminator, a fill
//             threshold, a full FIFO or an idle timeout, then releases them in
//             a burst so the USB side can build full packets.
//  Revision : 1.0  initial release
// ============================================================================
module usbcdc_txbuf #(
    parameter int         DEPTH        = 64,
    parameter int         FLUSH_THRESH = 32,
    parameter int         IDLE_TIMEOUT = 48000,
    parameter logic [7:0] FLUSH_CHAR   = 8'h0A
) (
    input  logic                     clk48,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [PW-1:0] C_DEPTH  = PW'(DEPTH);
    localparam logic [PW-1:0] C_THRESH = PW'(FLUSH_THRESH);
    localparam logic [TW-1:0] C_TMAX   = TW'(IDLE_TIMEOUT);

    typedef enum logic [0:0] {
        ST_HOLD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      mem [DEPTH];

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [PW-1:0]   level_d;

    // FIFO status, handshakes and pointer advance; pointers carry one extra
    // wrap bit so full and empty are distinguishable.
    always_comb begin
        level     = wr_ptr_q - rd_ptr_q;
        empty     = (level == '0);
        full      = (level == C_DEPTH);
        in_ready  = rst_n & ~full;
        out_valid = (state_q == ST_DRAIN) & ~empty;
        out_data  = mem[rd_ptr_q[AW-1:0]];
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        level_d   = wr_ptr_d - rd_ptr_d;
    end

    // Burst control: HOLD collects bytes, DRAIN presents them until empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: begin
                if ((push && (in_data == FLUSH_CHAR)) ||
                    (level_d >= C_THRESH) ||
                    full ||
                    ((timer_q == C_TMAX) && !empty)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (level_d == '0) begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    // Idle timer: runs only while data sits untouched in HOLD, saturating.
    always_comb begin
        timer_d = '0;
        if ((state_q == ST_HOLD) && !empty && !push) begin
            timer_d = (timer_q == C_TMAX) ? timer_q : timer_q + TW'(1);
        end
    end

    // Control state registers; reset discards all buffered bytes.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HOLD;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            timer_q  <= timer_d;
        end
    end

    // Byte storage; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk48) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usbcdc_txbuf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usbcdc_txbuf
//  Purpose  : Self-checking bench for usbcdc_txbuf. A behavioural model tracks
//             occupancy, burst mode and idle time; accepted bytes go into a
//             scoreboard queue that a monitor drains against the DUT output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_usbcdc_txbuf;

    localparam int         DEPTH = 16;
    localparam int         THR   = 8;
    localparam int         TO    = 10;
    localparam logic [7:0] FC    = 8'h0A;

    logic                   clk48     = 1'b0;
    logic                   rst_n     = 1'b0;
    logic [7:0]             in_data   = 8'h00;
    logic                   in_valid  = 1'b0;
    logic                   out_ready = 1'b0;
    logic                   in_ready;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic [$clog2(DEPTH):0] level;

    int total = 0;
    int bad   = 0;

    always #5 clk48 = ~clk48;

    usbcdc_txbuf #(
        .DEPTH        (DEPTH),
        .FLUSH_THRESH (THR),
        .IDLE_TIMEOUT (TO),
        .FLUSH_CHAR   (FC)
    ) dut (
        .clk48     (clk48),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    // ---------------- reference model ----------------
    int         m_cnt   = 0;     // bytes held
    int         m_idle  = 0;     // cycles since last write while holding
    bit         m_drain = 1'b0;  // burst in progress
    logic [7:0] exp_q[$];        // scoreboard of accepted bytes, oldest first

    always @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   = 0;
            m_idle  = 0;
            m_drain = 1'b0;
            exp_q.delete();
        end else begin
            bit acc;
            bit take;
            bit go;
            int nxt;
            acc  = in_valid && (m_cnt < DEPTH);
            take = m_drain && (m_cnt > 0) && out_ready;
            if (acc) exp_q.push_back(in_data);
            nxt = m_cnt + int'(acc) - int'(take);
            if (!m_drain) begin
                go = (acc && in_data == FC) || (nxt >= THR) || (m_cnt == DEPTH) ||
                     (m_idle == TO && m_cnt > 0);
                if (m_cnt > 0 && !acc) m_idle = (m_idle < TO) ? m_idle + 1 : TO;
                else                   m_idle = 0;
                if (go) m_drain = 1'b1;
            end else begin
                m_idle = 0;
                if (nxt == 0) m_drain = 1'b0;
            end
            m_cnt = nxt;
        end
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk48) begin
        check("in_ready",  int'(in_ready),  int'(rst_n && m_cnt < DEPTH));
        check("out_valid", int'(out_valid), int'(rst_n && m_drain && m_cnt > 0));
        check("level",     int'(level),     m_cnt);
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_data actual=%0h required=<no byte pending> at t=%0t",
                         out_data, $time);
            end else begin
                check("out_data", int'(out_data), int'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [7:0] d, input bit r);
        @(posedge clk48);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) drive(1'b0, 8'h00, r);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk48);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (n) @(posedge clk48);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == FC) b = 8'h41;
        return b;
    endfunction

    initial begin
        repeat (3) @(posedge clk48);
        #1;
        rst_n = 1'b1;
        idle(2, 1'b1);

        // line terminator flush: "hi\n"
        drive(1'b1, 8'h68, 1'b1);
        drive(1'b1, 8'h69, 1'b1);
        drive(1'b1, FC,    1'b1);
        idle(6, 1'b1);

        // idle-timeout flush
        for (int i = 0; i < 5; i++) drive(1'b1, rnd_byte(), 1'b1);
        idle(TO + 6, 1'b1);

        // threshold flush with stalled consumer
        for (int i = 0; i < THR - 1; i++) drive(1'b1, rnd_byte(), 1'b0);
        idle(4, 1'b0);
        drive(1'b1, rnd_byte(), 1'b0);
        idle(20, 1'b0);
        idle(THR + 4, 1'b1);

        // fill to full, then release while still offering bytes
        for (int i = 0; i < DEPTH + 6; i++) drive(1'b1, rnd_byte(), 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, rnd_byte(), 1'b1);
        idle(DEPTH + 8, 1'b1);

        // push and pop together at level 1 while draining
        drive(1'b1, FC,    1'b1);
        drive(1'b1, 8'h55, 1'b1);
        drive(1'b1, 8'h66, 1'b1);
        idle(5, 1'b1);

        // reset in the middle of a burst
        for (int i = 0; i < 12; i++) drive(1'b1, rnd_byte(), 1'b0);
        do_reset(1);
        idle(TO + 5, 1'b1);

        // random traffic with a busy and a mostly stalled consumer
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 1000; i++) begin
                logic [7:0] d;
                d = ($urandom_range(7) == 0) ? FC : rnd_byte();
                drive(1'($urandom_range(1)), d,
                      (ph == 0) ? ($urandom_range(9) < 7) : ($urandom_range(9) < 2));
            end
        end
        idle(DEPTH + TO + 10, 1'b1);

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
